// File: rtl/demux1x8_deser.sv
// demux1x8_deser: serial-to-parallel demultiplexer.
// Each accepted serial bit is steered into one slot of an assembly register,
// chosen by a running select counter; completed words are published on a
// valid/ready output port.
// Optional feature macro: DEMUX_MSB_FIRST_EN (reverse bit order, first bit
// lands in slot WIDTH-1). Default build is LSB-first.

module demux1x8_deser #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] bit_idx,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic [WIDTH-1:0] assembly;
    logic [WIDTH-1:0] word_next;
    logic [IDX_W-1:0] slot;
    logic             last_slot;
    logic             accept;
    logic             complete;
    logic             taken;

    // The word-completing bit is the only one that must wait for the
    // output register to free up; earlier bits keep filling during a stall.
    assign last_slot = (bit_idx == LAST_IDX);
    assign in_ready  = !(out_valid && !out_ready && last_slot);
    assign accept    = in_valid && in_ready;
    assign complete  = accept && last_slot;
    assign taken     = out_valid && out_ready;

`ifdef DEMUX_MSB_FIRST_EN
    // MSB-first: counter still runs 0..WIDTH-1, physical slot is mirrored.
    assign slot = LAST_IDX - bit_idx;
`else
    // LSB-first: counter value is the physical slot.
    assign slot = bit_idx;
`endif

    // Word as it will look once the current bit is merged in; used to
    // publish the completed word without waiting a cycle for assembly.
    always_comb begin
        word_next       = assembly;
        word_next[slot] = in_bit;
    end

    // Select counter: advances on every accepted bit, wraps naturally
    // because WIDTH is a power of two; clr restarts the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
        end else if (clr) begin
            bit_idx <= '0;
        end else if (accept) begin
            bit_idx <= bit_idx + 1'b1;
        end
    end

    // Assembly register: only the selected slot is written, others hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            assembly <= '0;
        end else if (clr) begin
            assembly <= '0;
        end else if (accept) begin
            assembly[slot] <= in_bit;
        end
    end

    // Output register: a completing word always wins over a handshake on
    // the same edge, so valid stays high and data refreshes back-to-back.
    // clr drops the pending word but leaves the last data visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (complete) begin
            out_valid <= 1'b1;
            out_data  <= word_next;
        end else if (taken) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux1x8_deser.sv
// tb_demux1x8_deser: self-checking bench for demux1x8_deser.
// A queue-based reference model tracks accepted bits and the pending output
// word; directed sequences plus randomized traffic are checked every cycle.

module tb_demux1x8_deser;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit               model_bits[$];
    logic             model_valid;
    logic [WIDTH-1:0] model_data;
    logic             last_accepted;

    demux1x8_deser #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bit_idx   (bit_idx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] buildWord();
        logic [WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < WIDTH; k++) begin
`ifdef DEMUX_MSB_FIRST_EN
            w[WIDTH-1-k] = model_bits[k];
`else
            w[k] = model_bits[k];
`endif
        end
        return w;
    endfunction

    // Serial bit k of word w, ordered so the DUT reassembles exactly w.
    function automatic logic serialBit(input logic [WIDTH-1:0] w, input int k);
`ifdef DEMUX_MSB_FIRST_EN
        return w[WIDTH-1-k];
`else
        return w[k];
`endif
    endfunction

    task automatic resetModel();
        model_bits.delete();
        model_valid = 1'b0;
        model_data  = '0;
    endtask

    // One clock cycle: drive at negedge, check outputs shortly after,
    // then advance the model to what the next rising edge should produce.
    task automatic applyStimulus(input logic b, input logic v, input logic r, input logic c);
        logic exp_ready;
        logic acc;
        @(negedge clk);
        in_bit    = b;
        in_valid  = v;
        out_ready = r;
        clr       = c;
        #1;
        exp_ready = !(model_valid && !r && (model_bits.size() == WIDTH - 1));
        checkOutput("in_ready",  32'(in_ready),  32'(exp_ready));
        checkOutput("bit_idx",   32'(bit_idx),   32'(model_bits.size()));
        checkOutput("out_valid", 32'(out_valid), 32'(model_valid));
        checkOutput("out_data",  32'(out_data),  32'(model_data));
        acc = v && exp_ready && !c;
        last_accepted = acc;
        if (c) begin
            model_bits.delete();
            model_valid = 1'b0;
        end else begin
            if (model_valid && r) model_valid = 1'b0;
            if (acc) begin
                model_bits.push_back(b);
                if (model_bits.size() == WIDTH) begin
                    model_data  = buildWord();
                    model_valid = 1'b1;
                    model_bits.delete();
                end
            end
        end
    endtask

    task automatic feedWord(input logic [WIDTH-1:0] w, input logic r);
        for (int k = 0; k < WIDTH; k++) applyStimulus(serialBit(w, k), 1'b1, r, 1'b0);
    endtask

    initial begin
        logic hold_v;
        logic hold_b;
        logic v, b, r, c;

        rst_n = 1'b0; clr = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        resetModel();
        #3;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_bit_idx",   32'(bit_idx),   32'd0);
        checkOutput("rst_out_data",  32'(out_data),  32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // T2: bits 1,0,1,1,0,0,1,0 in arrival order
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_valid", 32'(out_valid), 32'd1);
`ifdef DEMUX_MSB_FIRST_EN
        checkOutput("t2_word", 32'(out_data), 32'h0B2);
`else
        checkOutput("t2_word", 32'(out_data), 32'h04D);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_pulse_end", 32'(out_valid), 32'd0);

        // T3: back-to-back words A5 then 3C
        feedWord(8'hA5, 1'b1);
        applyStimulus(serialBit(8'h3C, 0), 1'b1, 1'b1, 1'b0);
        checkOutput("t3_first", 32'(out_data), 32'h0A5);
        for (int k = 1; k < WIDTH; k++) applyStimulus(serialBit(8'h3C, k), 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_second", 32'(out_data), 32'h03C);

        // T4: backpressure with FF pending, then 01 stalls on its last bit
        feedWord(8'hFF, 1'b0);
        feedWord(8'h01, 1'b0);
        checkOutput("t4_stall_ready", 32'(in_ready), 32'd0);
        checkOutput("t4_hold_data",   32'(out_data), 32'h0FF);
        applyStimulus(serialBit(8'h01, WIDTH-1), 1'b1, 1'b0, 1'b0);
        applyStimulus(serialBit(8'h01, WIDTH-1), 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_new_data", 32'(out_data), 32'h001);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // T5: clr after 3 bits, then a clean 81
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        feedWord(8'h81, 1'b1);
        checkOutput("t5_idx_after_clr", 32'(model_bits.size()), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_word", 32'(out_data), 32'h081);

        // T1: async reset asserted between edges in the middle of a word
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t1_bit_idx",   32'(bit_idx),   32'd0);
        checkOutput("t1_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t1_out_data",  32'(out_data),  32'd0);
        resetModel();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic; the source holds an unaccepted bit
        hold_v = 1'b0;
        hold_b = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (hold_v) begin
                v = 1'b1;
                b = hold_b;
            end else begin
                v = ($urandom_range(0, 9) < 7);
                b = 1'($urandom_range(0, 1));
            end
            r = ($urandom_range(0, 9) < 5);
            c = ($urandom_range(0, 99) < 3);
            applyStimulus(b, v, r, c);
            hold_v = v && !last_accepted && !c;
            hold_b = b;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
